// File: rtl/frs_pkg.sv
// Shared types and constants for the Feistel round sequencer.
// Contents: state encoding, DES one-bit-shift table, mode codes, table lookup.
package frs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int DES_ROUNDS = 16;

  // Bit r set: DES round r rotates C/D by one place instead of two.
  localparam logic [16:0] DES_ONE_SHIFT =
    (17'd1 << 1) | (17'd1 << 2) | (17'd1 << 9) | (17'd1 << 16);

  function automatic logic des_one_shift(input int unsigned r);
    logic res;
    res = 1'b0;
    if (r <= 32'd16) res = DES_ONE_SHIFT[r[4:0]];
    return res;
  endfunction

endpackage

// File: rtl/feistel_round_sequencer_key_shift_ctl.sv
// Key-schedule control: maps (d, round) to rotate direction and amount.
// Ports: active_i/run_i gates, d_i, round_i in; key_dir_o, shift_two_o out.
module frs_key_shift_ctl
  import frs_pkg::*;
#(
  parameter int NUM_ROUNDS = 16,
  parameter int RC_W       = $clog2(NUM_ROUNDS + 1)
) (
  input  logic            active_i,
  input  logic            run_i,
  input  logic            d_i,
  input  logic [RC_W-1:0] round_i,
  output logic            key_dir_o,
  output logic            shift_two_o
);

  localparam logic DES_SCHED = (NUM_ROUNDS == DES_ROUNDS);

  // Decrypt round 1 gets shift_two=0; the datapath applies no rotation
  // at all there (decrypt-hold), so one table serves both directions.
  assign key_dir_o   = active_i & d_i;
  assign shift_two_o = run_i & DES_SCHED
                     & ~des_one_shift(32'(round_i));

endmodule

// File: rtl/feistel_round_sequencer.sv
// Control FSM for a DES / TDES-EDE Feistel datapath: LOAD, RUN, FINAL, DONE.
// Ports: start/mode/ready/abort in; status, counters, key and datapath enables out.
// Build option: define FRS_TDES_EN to honour NUM_PASSES (EDE sequencing).
module feistel_round_sequencer
  import frs_pkg::*;
#(
  parameter int NUM_ROUNDS = 16,
  parameter int NUM_PASSES = 3,
  parameter int RC_W       = $clog2(NUM_ROUNDS + 1),
  parameter int PC_W       = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic            key_ready,
  input  logic            data_ready,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [2:0]      state,
  output logic [RC_W-1:0] round_count,
  output logic [PC_W-1:0] pass_count,
  output logic [PC_W-1:0] key_sel,
  output logic            key_dir,
  output logic            shift_two,
  output logic            key_load,
  output logic            en_ip,
  output logic            load_data,
  output logic            en_round,
  output logic            en_fp,
  output logic            sel_output
);

`ifdef FRS_TDES_EN
  localparam int PASSES = NUM_PASSES;
`else
  localparam int PASSES = 1;
`endif

  localparam logic [RC_W-1:0] LAST_RND  = RC_W'(NUM_ROUNDS);
  localparam logic [PC_W-1:0] LAST_PASS = PC_W'(PASSES - 1);

  state_e          state_q, state_d;
  logic [RC_W-1:0] round_q, round_d;
  logic [PC_W-1:0] pass_q, pass_d;
  logic            mode_q, mode_d;
  logic            accept;
  logic            d_eff;
  logic            in_run;

  assign accept = start & key_ready & data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      pass_q  <= '0;
      mode_q  <= MODE_ENC;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      pass_q  <= pass_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    pass_d  = pass_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          state_d = ST_LOAD;
          mode_d  = mode;
          pass_d  = '0;
          round_d = '0;
        end else if (start) begin
          state_d = ST_ERROR;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        round_d = RC_W'(1);
      end
      ST_RUN: begin
        if (round_q == LAST_RND) begin
          round_d = '0;
          if (pass_q != LAST_PASS) begin
            pass_d  = pass_q + PC_W'(1);
            state_d = ST_LOAD;
          end else begin
            state_d = ST_FINAL;
          end
        end else begin
          round_d = round_q + RC_W'(1);
        end
      end
      ST_FINAL: state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        pass_d  = '0;
      end
      ST_ERROR: begin
        if (accept) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        round_d = '0;
        pass_d  = '0;
      end
    endcase
    // Abort wins over everything outside IDLE; done is never reached.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      round_d = '0;
      pass_d  = '0;
    end
  end

  assign in_run     = (state_q == ST_RUN);
  assign busy       = (state_q == ST_LOAD) | in_run
                    | (state_q == ST_FINAL);
  assign done       = (state_q == ST_DONE);
  assign sel_output = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign state      = state_q;
  assign round_count = round_q;
  assign pass_count = pass_q;
  assign key_load   = (state_q == ST_LOAD);
  assign en_ip      = key_load & (pass_q == '0);
  assign load_data  = key_load & (pass_q == '0);
  assign en_round   = in_run;
  assign en_fp      = (state_q == ST_FINAL);

`ifdef FRS_TDES_EN
  // EDE: the middle pass runs opposite to the requested direction.
  assign d_eff   = mode_q ^ (pass_q == PC_W'(1));
  assign key_sel = !busy ? '0
                 : (mode_q == MODE_DEC) ? (LAST_PASS - pass_q)
                 : pass_q;
`else
  assign d_eff   = mode_q;
  assign key_sel = '0;
`endif

  frs_key_shift_ctl #(
    .NUM_ROUNDS(NUM_ROUNDS),
    .RC_W      (RC_W)
  ) u_ksc (
    .active_i   (busy),
    .run_i      (in_run),
    .d_i        (d_eff),
    .round_i    (round_q),
    .key_dir_o  (key_dir),
    .shift_two_o(shift_two)
  );

endmodule

// File: tb/tb_feistel_round_sequencer.sv
// Directed self-checking bench for feistel_round_sequencer (R=16).
// Follows FRS_TDES_EN: three EDE passes when defined, single DES otherwise.
module tb_feistel_round_sequencer;

`ifdef FRS_TDES_EN
  localparam int NP = 3;
`else
  localparam int NP = 1;
`endif
  localparam int NR = 16;

  logic       clk = 1'b0;
  logic       rst, start, mode, key_ready, data_ready, abort;
  logic       busy, done, error;
  logic [2:0] state;
  logic [4:0] round_count;
  logic [1:0] pass_count, key_sel;
  logic       key_dir, shift_two, key_load, en_ip, load_data;
  logic       en_round, en_fp, sel_output;
  logic [22:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  feistel_round_sequencer #(
    .NUM_ROUNDS(NR),
    .NUM_PASSES(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .key_ready(key_ready), .data_ready(data_ready), .abort(abort),
    .busy(busy), .done(done), .error(error), .state(state),
    .round_count(round_count), .pass_count(pass_count),
    .key_sel(key_sel), .key_dir(key_dir), .shift_two(shift_two),
    .key_load(key_load), .en_ip(en_ip), .load_data(load_data),
    .en_round(en_round), .en_fp(en_fp), .sel_output(sel_output)
  );

  assign obs = {state, round_count, pass_count, key_sel, key_dir,
                shift_two, key_load, en_ip, load_data, en_round,
                en_fp, busy, done, sel_output, error};

  function automatic logic [22:0] exp_vec(input int st, input int rnd,
                                          input int pas, input int ks,
                                          input bit kd);
    logic s2;
    logic ld;
    s2 = (st == 2) && !(rnd == 1 || rnd == 2 || rnd == 9 || rnd == 16);
    ld = (st == 1) && (pas == 0);
    return {st[2:0], rnd[4:0], pas[1:0], ks[1:0], kd, s2,
            (st == 1), ld, ld, (st == 2), (st == 3),
            (st >= 1 && st <= 3), (st == 4), (st == 4), (st == 5)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; mode = 0; abort = 0;
    key_ready = 1; data_ready = 1;
    tick();
    tick();
    n_cmp++;
    if (obs !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_state got=%h want=%h", obs, 23'd0);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (obs !== 23'd0) begin
      n_bad++;
      $display("FAIL idle_after_reset got=%h want=%h", obs, 23'd0);
    end
  endtask

  // Whole block; busy-time start pulse and ready drop must be ignored.
  task automatic test_block(input bit m, input string nm);
    int tot, done_at, st, rnd, p, o, ks;
    bit d, bz, kd;
    logic [22:0] e;
    tot = NP * (NR + 1) + 3;
    done_at = -1;
    mode = m; start = 1; key_ready = 1; data_ready = 1;
    for (int k = 1; k <= tot; k++) begin
      tick();
      rnd = 0;
      if (k <= NP * (NR + 1)) begin
        p = (k - 1) / (NR + 1);
        o = (k - 1) % (NR + 1);
        st = (o == 0) ? 1 : 2;
        rnd = o;
      end else if (k == NP * (NR + 1) + 1) begin
        st = 3; p = NP - 1;
      end else if (k == NP * (NR + 1) + 2) begin
        st = 4; p = NP - 1;
      end else begin
        st = 0; p = 0;
      end
      d  = m ^ ((NP > 1) && (p == 1));
      bz = (st >= 1 && st <= 3);
      ks = !bz ? 0 : (m ? (NP - 1 - p) : p);
      kd = bz && d;
      e  = exp_vec(st, rnd, p, ks, kd);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h", nm, k, obs, e);
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (k == 1) start = 0;
      if (k == 4) begin
        start = 1; key_ready = 0; data_ready = 0;
      end
      if (k == 5) start = 0;
    end
    key_ready = 1; data_ready = 1;
    n_cmp++;
    if (done_at != NP * (NR + 1) + 2) begin
      n_bad++;
      $display("FAIL %s_latency got=%0d want=%0d",
               nm, done_at, NP * (NR + 1) + 2);
    end
  endtask

  task automatic test_error();
    bit seen;
    mode = 0; start = 1; key_ready = 0; data_ready = 1;
    tick();
    n_cmp++;
    if (obs !== exp_vec(5, 0, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL err_enter got=%h want=%h", obs, exp_vec(5, 0, 0, 0, 0));
    end
    start = 0; key_ready = 1;
    tick();
    n_cmp++;
    if (obs !== exp_vec(5, 0, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL err_hold got=%h want=%h", obs, exp_vec(5, 0, 0, 0, 0));
    end
    start = 1;
    tick();
    start = 0;
    n_cmp++;
    if (obs !== 23'd0) begin
      n_bad++;
      $display("FAIL err_exit got=%h want=%h", obs, 23'd0);
    end
    tick();
    n_cmp++;
    if (obs !== 23'd0) begin
      n_bad++;
      $display("FAIL err_no_launch got=%h want=%h", obs, 23'd0);
    end
    start = 1;
    tick();
    start = 0;
    n_cmp++;
    if (obs !== exp_vec(1, 0, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL err_relaunch got=%h want=%h", obs, exp_vec(1, 0, 0, 0, 0));
    end
    seen = 0;
    for (int k = 0; k < NP * (NR + 1) + 4; k++) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b1 || obs !== 23'd0) begin
      n_bad++;
      $display("FAIL err_block_done got=%b want=1", seen);
    end
  endtask

  task automatic test_abort();
    bit seen;
    mode = 0; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 7; k++) tick();
    n_cmp++;
    if (obs !== exp_vec(2, 7, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL abort_pre got=%h want=%h", obs, exp_vec(2, 7, 0, 0, 0));
    end
    abort = 1;
    tick();
    abort = 0;
    n_cmp++;
    if (obs !== 23'd0) begin
      n_bad++;
      $display("FAIL abort_idle got=%h want=%h", obs, 23'd0);
    end
    seen = 0;
    for (int k = 0; k < NP * (NR + 1) + 4; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_done got=%b want=0", seen);
    end
    abort = 1; start = 1;
    tick();
    abort = 0; start = 0;
    n_cmp++;
    if (obs !== 23'd0) begin
      n_bad++;
      $display("FAIL abort_start_idle got=%h want=%h", obs, 23'd0);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 4; k++) tick();
    n_cmp++;
    if (obs !== exp_vec(2, 4, 0, NP - 1, 1)) begin
      n_bad++;
      $display("FAIL rstmid_pre got=%h want=%h",
               obs, exp_vec(2, 4, 0, NP - 1, 1));
    end
    #2 rst = 1;
    #1;
    n_cmp++;
    if (obs !== 23'd0) begin
      n_bad++;
      $display("FAIL rstmid_async got=%h want=%h", obs, 23'd0);
    end
    tick();
    rst = 0;
    tick();
    n_cmp++;
    if (obs !== 23'd0) begin
      n_bad++;
      $display("FAIL rstmid_after got=%h want=%h", obs, 23'd0);
    end
  endtask

  initial begin
    test_reset();
    test_block(1'b0, "enc");
    test_block(1'b1, "dec");
    test_error();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
